// File: rtl/sprite_pkg.sv
// Shared sizing constants and FSM state type for the sprite ROM fetch arbiter.
package sprite_pkg;

  localparam int NUM_REQ   = 4;
  localparam int BURST_LEN = 16;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int ROW_W     = 4;
  localparam int COL_W     = 4;
  localparam int ID_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester, ROM and pixel-stream signals of the sprite ROM arbiter.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = sprite_pkg::NUM_REQ,
  parameter int ADDR_W  = sprite_pkg::ADDR_W,
  parameter int DATA_W  = sprite_pkg::DATA_W
);
  import sprite_pkg::*;

  // req[i] is a level held until grant[i] pulses for one cycle; the row is
  // captured on that grant. pix_valid has no ready: every beat must be taken.
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*ROW_W-1:0] row;
  logic [NUM_REQ-1:0]       grant;
  logic [ADDR_W-1:0]        rom_address;
  logic                     rom_chipselect;
  logic                     rom_clken;
  logic [DATA_W-1:0]        rom_readdata;
  logic [DATA_W-1:0]        pix_data;
  logic                     pix_valid;
  logic [ID_W-1:0]          pix_id;
  logic [COL_W-1:0]         pix_col;
  logic                     pix_last;
  logic                     busy;
  state_e                   state;

  modport slave (
    input  req, row, rom_readdata,
    output grant, rom_address, rom_chipselect, rom_clken,
           pix_data, pix_valid, pix_id, pix_col, pix_last, busy, state
  );

  modport master (
    output req, row, rom_readdata,
    input  grant, rom_address, rom_chipselect, rom_clken,
           pix_data, pix_valid, pix_id, pix_col, pix_last, busy, state
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after the last winner.
module rr_arbiter #(
  parameter int NUM_REQ = sprite_pkg::NUM_REQ,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_winner_i,
  output logic [NUM_REQ-1:0] winner_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_winner_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Grants one requester at a time a 16-word sprite-row burst from a read-only
// ROM and streams the returned words out tagged with owner and column.
module sprite_rom_arbiter #(
  parameter int NUM_REQ   = sprite_pkg::NUM_REQ,
  parameter int BURST_LEN = sprite_pkg::BURST_LEN,
  parameter int ADDR_W    = sprite_pkg::ADDR_W,
  parameter int DATA_W    = sprite_pkg::DATA_W
) (
  input logic                 clk,
  input logic                 reset,
  sprite_rom_arbiter_if.slave bus
);
  import sprite_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(BURST_LEN - 1);

  state_e             state_q;
  logic [NUM_REQ-1:0] winner, grant_q;
  logic [IDX_W-1:0]   win_idx, last_q, id_q;
  logic [ROW_W-1:0]   row_sel, row_q;
  logic [COL_W-1:0]   col_q, col_d, pix_col_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               cs_q, pix_valid_q, pix_last_q;
  logic [ID_W-1:0]    pix_id_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i        (bus.req),
    .last_winner_i(last_q),
    .winner_o     (winner)
  );

  always_comb begin
    win_idx = '0;
    row_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        win_idx = IDX_W'(i);
        row_sel = bus.row[i*ROW_W +: ROW_W];
      end
    end
  end

  assign col_d = col_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      id_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      cs_q        <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      pix_col_q   <= '0;
      pix_id_q    <= '0;
    end else begin
      grant_q     <= '0;
      // The ROM answers one cycle after the address, so the tag trails by one.
      pix_valid_q <= cs_q;
      pix_last_q  <= cs_q && (col_q == LAST_COL);
      pix_col_q   <= col_q;
      pix_id_q    <= ID_W'(id_q);
      case (state_q)
        ST_IDLE: begin
          if (|bus.req) begin
            grant_q <= winner;
            last_q  <= win_idx;
            id_q    <= win_idx;
            row_q   <= row_sel;
            col_q   <= '0;
            addr_q  <= ADDR_W'({row_sel, {COL_W{1'b0}}});
            cs_q    <= 1'b1;
            state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (col_q == LAST_COL) begin
            cs_q    <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            col_q  <= col_d;
            addr_q <= ADDR_W'({row_q, col_d});
          end
        end
        ST_DRAIN: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant          = grant_q;
  assign bus.rom_address    = addr_q;
  assign bus.rom_chipselect = cs_q;
  assign bus.rom_clken      = ~reset;
  assign bus.pix_data       = DATA_W'(bus.rom_readdata);
  assign bus.pix_valid      = pix_valid_q;
  assign bus.pix_id         = pix_id_q;
  assign bus.pix_col        = pix_col_q;
  assign bus.pix_last       = pix_last_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.state          = state_q;

endmodule
